// File: rtl/integration_pkg.sv
// Shared widths and FSM state encoding for the quadratic series summation block.
package integration_pkg;

  localparam int unsigned OPW  = 33;
  localparam int unsigned NW   = 8;
  localparam int unsigned ACCW = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/integration_solver.sv
// Sums a*x^2+b*x+c over x=0..n-1 using forward differences (no multipliers),
// one term per cycle, with a valid/ready handshake on the result.
module integration_solver #(
  parameter int unsigned OPW  = integration_pkg::OPW,
  parameter int unsigned NW   = integration_pkg::NW,
  parameter int unsigned ACCW = integration_pkg::ACCW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   start_ready,
  input  logic signed [OPW-1:0]  a,
  input  logic signed [OPW-1:0]  b,
  input  logic signed [OPW-1:0]  c,
  input  logic        [NW-1:0]   n,
  output logic                   busy,
  output logic        [OPW-1:0]  ans,
  output logic                   ans_valid,
  input  logic                   ans_ready,
  output logic                   ovf
);

  import integration_pkg::*;

  state_e                  state;
  logic signed [ACCW-1:0]  sum;
  logic signed [ACCW-1:0]  f;
  logic signed [ACCW-1:0]  d1;
  logic signed [ACCW-1:0]  d2;
  logic        [NW-1:0]    cnt;

  logic signed [ACCW-1:0]  a_x;
  logic signed [ACCW-1:0]  b_x;
  logic signed [ACCW-1:0]  c_x;
  logic signed [ACCW-1:0]  sum_nxt;
  logic        [ACCW-OPW:0] sum_top;
  logic                    ovf_nxt;

  // Operand sign extension and the accumulate step feeding the result registers.
  always_comb begin
    a_x     = ACCW'(a);
    b_x     = ACCW'(b);
    c_x     = ACCW'(c);
    sum_nxt = sum + f;
    sum_top = sum_nxt[ACCW-1:OPW-1];
    ovf_nxt = !((&sum_top) || !(|sum_top));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      start_ready <= 1'b1;
      busy        <= 1'b0;
      ans_valid   <= 1'b0;
      ans         <= '0;
      ovf         <= 1'b0;
      sum         <= '0;
      f           <= '0;
      d1          <= '0;
      d2          <= '0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            f           <= c_x;
            d1          <= a_x + b_x;
            d2          <= a_x <<< 1;
            sum         <= '0;
            cnt         <= n;
            start_ready <= 1'b0;
            if (n == NW'(0)) begin
              // Empty series: result is zero and available next cycle.
              state     <= DONE;
              ans_valid <= 1'b1;
              ans       <= '0;
              ovf       <= 1'b0;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          sum <= sum_nxt;
          f   <= f + d1;
          d1  <= d1 + d2;
          cnt <= cnt - NW'(1);
          if (cnt == NW'(1)) begin
            state     <= DONE;
            busy      <= 1'b0;
            ans_valid <= 1'b1;
            ans       <= sum_nxt[OPW-1:0];
            ovf       <= ovf_nxt;
          end
        end
        DONE: begin
          if (ans_ready) begin
            state       <= IDLE;
            ans_valid   <= 1'b0;
            start_ready <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          busy        <= 1'b0;
          ans_valid   <= 1'b0;
          start_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_integration_solver.sv
// Self-checking bench for integration_solver against a direct polynomial-sum model.
module tb_integration_solver;
  import integration_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic                  start_ready;
  logic signed [OPW-1:0] a, b, c;
  logic        [NW-1:0]  n;
  logic                  busy;
  logic        [OPW-1:0] ans;
  logic                  ans_valid;
  logic                  ans_ready;
  logic                  ovf;

  int unsigned pass_cnt = 0;
  int unsigned total    = 0;

  logic [OPW-1:0] exp_ans;
  logic           exp_ovf;
  int             lat;

  integration_solver dut (
    .clk(clk), .rst(rst), .start(start), .start_ready(start_ready),
    .a(a), .b(b), .c(c), .n(n), .busy(busy), .ans(ans),
    .ans_valid(ans_valid), .ans_ready(ans_ready), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Reference: evaluate the polynomial at every x and add, in wide arithmetic.
  function automatic void model(input logic signed [OPW-1:0] ia, ib, ic,
                                input logic [NW-1:0] in_n,
                                output logic [OPW-1:0] r, output logic o);
    longint s;
    longint lim;
    s   = 0;
    lim = longint'(1) <<< (OPW - 1);
    for (int x = 0; x < int'(in_n); x++)
      s += longint'(ia) * x * x + longint'(ib) * x + longint'(ic);
    r = OPW'(s);
    o = (s < -lim) || (s >= lim);
  endfunction

  function automatic logic signed [OPW-1:0] rand_op();
    logic [OPW-1:0] v;
    v = OPW'({$urandom_range(0, 1), $urandom()});
    if ($urandom_range(0, 2) == 0) v = OPW'($signed($urandom_range(0, 40)) - 20);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic signed [OPW-1:0] ia, ib, ic, input logic [NW-1:0] in_n);
    a = ia; b = ib; c = ic; n = in_n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Returns cycles after capture until ans_valid (1 = cycle T+1), or -1 on timeout.
  task automatic wait_valid(input bit noise, output int k);
    k = 1;
    while (ans_valid !== 1'b1 && k < 400) begin
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        a = rand_op(); b = rand_op(); c = rand_op(); n = NW'($urandom());
      end
      tick();
      k++;
    end
    start = 1'b0;
    if (ans_valid !== 1'b1) k = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; ans_ready = 1'b1;
    a = '0; b = '0; c = '0; n = '0;
    tick(); tick();
    rst = 1'b0;
    total++; if (start_ready !== 1'b1) $display("FAIL reset_start_ready got=%b exp=1", start_ready); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else pass_cnt++;
    total++; if (ans_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", ans_valid); else pass_cnt++;
    total++; if (ans !== '0 || ovf !== 1'b0) $display("FAIL reset_ans got=%h/%b exp=0/0", ans, ovf); else pass_cnt++;
  endtask

  task automatic test_directed();
    logic signed [OPW-1:0] ta [4], tb_ [4], tc [4];
    logic [NW-1:0] tn [4];
    ta = '{33'sd1, 33'sd0, -33'sd1, 33'sd0};
    tb_ = '{33'sd0, 33'sd0, 33'sd2, 33'sd0};
    tc = '{33'sd0, 33'sd5, -33'sd3, 33'sh0FFFFFFFF};
    tn = '{8'd4, 8'd3, 8'd3, 8'd2};
    ans_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      model(ta[i], tb_[i], tc[i], tn[i], exp_ans, exp_ovf);
      launch(ta[i], tb_[i], tc[i], tn[i]);
      total++; if (busy !== 1'b1) $display("FAIL dir%0d_busy got=%b exp=1", i, busy); else pass_cnt++;
      wait_valid(1'b0, lat);
      total++; if (lat !== int'(tn[i]) + 1) $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, int'(tn[i]) + 1); else pass_cnt++;
      total++; if (ans !== exp_ans || ovf !== exp_ovf) $display("FAIL dir%0d_ans got=%h/%b exp=%h/%b", i, ans, ovf, exp_ans, exp_ovf); else pass_cnt++;
      tick();
      total++; if (ans_valid !== 1'b0 || start_ready !== 1'b1) $display("FAIL dir%0d_one_cycle got=%b/%b exp=0/1", i, ans_valid, start_ready); else pass_cnt++;
      total++; if (ans !== exp_ans) $display("FAIL dir%0d_idle_hold got=%h exp=%h", i, ans, exp_ans); else pass_cnt++;
    end
    // Empty series right after a run, with nonzero coefficients.
    launch(33'sd7, 33'sd7, 33'sd7, 8'd0);
    total++; if (ans_valid !== 1'b1 || ans !== '0 || ovf !== 1'b0) $display("FAIL n0_result got=%b/%h/%b exp=1/0/0", ans_valid, ans, ovf); else pass_cnt++;
    tick();
  endtask

  task automatic test_hold_back_to_back();
    model(33'sd2, 33'sd1, 33'sd1, 8'd3, exp_ans, exp_ovf);
    ans_ready = 1'b0;
    launch(33'sd2, 33'sd1, 33'sd1, 8'd3);
    wait_valid(1'b1, lat);
    total++; if (lat !== 4) $display("FAIL hold_latency got=%0d exp=4", lat); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      start = 1'b1; a = 33'sd9; n = 8'd1;
      tick();
      total++; if (ans_valid !== 1'b1 || ans !== exp_ans || ovf !== 1'b0) $display("FAIL hold_stable%0d got=%b/%h/%b exp=1/%h/0", i, ans_valid, ans, ovf, exp_ans); else pass_cnt++;
    end
    start = 1'b0;
    ans_ready = 1'b1;
    tick();
    total++; if (start_ready !== 1'b1 || ans_valid !== 1'b0) $display("FAIL hold_release got=%b/%b exp=1/0", start_ready, ans_valid); else pass_cnt++;
    model(33'sd1, 33'sd0, 33'sd0, 8'd4, exp_ans, exp_ovf);
    launch(33'sd1, 33'sd0, 33'sd0, 8'd4);
    wait_valid(1'b0, lat);
    total++; if (lat !== 5 || ans !== exp_ans) $display("FAIL b2b_result got=%0d/%h exp=5/%h", lat, ans, exp_ans); else pass_cnt++;
    tick();
  endtask

  task automatic test_abort();
    bit seen;
    ans_ready = 1'b1;
    launch(33'sd3, 33'sd1, 33'sd2, 8'd200);
    for (int i = 0; i < 49; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (start_ready !== 1'b1 || busy !== 1'b0) $display("FAIL abort_ready got=%b/%b exp=1/0", start_ready, busy); else pass_cnt++;
    total++; if (ans !== '0 || ovf !== 1'b0) $display("FAIL abort_ans got=%h/%b exp=0/0", ans, ovf); else pass_cnt++;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (ans_valid === 1'b1) seen = 1'b1;
      tick();
    end
    total++; if (seen !== 1'b0) $display("FAIL abort_no_valid got=%b exp=0", seen); else pass_cnt++;
    // Start in the first cycle after reset release.
    rst = 1'b1; tick(); rst = 1'b0;
    model(33'sd1, 33'sd0, 33'sd0, 8'd4, exp_ans, exp_ovf);
    launch(33'sd1, 33'sd0, 33'sd0, 8'd4);
    wait_valid(1'b0, lat);
    total++; if (lat !== 5 || ans !== exp_ans || ovf !== exp_ovf) $display("FAIL abort_rerun got=%0d/%h exp=5/%h", lat, ans, exp_ans); else pass_cnt++;
    tick();
  endtask

  task automatic test_random();
    logic signed [OPW-1:0] ra, rb, rc;
    logic [NW-1:0] rn;
    int hold;
    for (int it = 0; it < 40; it++) begin
      ra = rand_op(); rb = rand_op(); rc = rand_op();
      rn = (it == 0) ? NW'(255) : NW'($urandom_range(0, 24));
      hold = $urandom_range(0, 3);
      ans_ready = (hold == 0);
      model(ra, rb, rc, rn, exp_ans, exp_ovf);
      total++; if (start_ready !== 1'b1) $display("FAIL rnd%0d_ready got=%b exp=1", it, start_ready); else pass_cnt++;
      launch(ra, rb, rc, rn);
      wait_valid(1'b1, lat);
      total++; if (lat !== int'(rn) + 1) $display("FAIL rnd%0d_latency got=%0d exp=%0d", it, lat, int'(rn) + 1); else pass_cnt++;
      total++; if (ans !== exp_ans || ovf !== exp_ovf) $display("FAIL rnd%0d_ans got=%h/%b exp=%h/%b", it, ans, ovf, exp_ans, exp_ovf); else pass_cnt++;
      for (int i = 0; i < hold; i++) begin
        tick();
        total++; if (ans_valid !== 1'b1 || ans !== exp_ans || ovf !== exp_ovf) $display("FAIL rnd%0d_hold got=%b/%h exp=1/%h", it, ans_valid, ans, exp_ans); else pass_cnt++;
      end
      ans_ready = 1'b1;
      tick();
      total++; if (ans_valid !== 1'b0 || busy !== 1'b0) $display("FAIL rnd%0d_exit got=%b/%b exp=0/0", it, ans_valid, busy); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold_back_to_back();
    test_abort();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
